// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter (with package pipeline and submodule alu)
//  Purpose  : Round-robin sharing of one ALU between N_REQ requesters, with a
//             one-entry tagged response buffer that supports 1 op/cycle.
//  Revision : 1.0 - initial release
// ============================================================================

package pipeline;
  localparam int XLEN = 32;
endpackage

// ----------------------------------------------------------------------------
//  alu : RV-style integer ALU; flags unsupported funct7/funct3 pairs and
//        forces a zero result for them.
// ----------------------------------------------------------------------------
module alu #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [SHW-1:0] shamt;
  logic           alt;

  assign shamt = op2[SHW-1:0];
  assign alt   = (funct7 == 7'b0100000);

  // Decode legality, then evaluate the operation; illegal pairs yield zero.
  always_comb begin
    illegal = !((funct7 == 7'b0000000) ||
                (alt && ((funct3 == 3'b000) || (funct3 == 3'b101))));
    result  = '0;
    if (!illegal) begin
      case (funct3)
        3'b000:  result = alt ? (op1 - op2) : (op1 + op2);
        3'b001:  result = op1 << shamt;
        3'b010:  result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
        3'b011:  result = {{(XLEN-1){1'b0}}, (op1 < op2)};
        3'b100:  result = op1 ^ op2;
        3'b101:  result = alt ? XLEN'($signed(op1) >>> shamt) : (op1 >> shamt);
        3'b110:  result = op1 | op2;
        3'b111:  result = op1 & op2;
        default: result = '0;
      endcase
    end
  end
endmodule

// ----------------------------------------------------------------------------
//  alu_arbiter : top level
// ----------------------------------------------------------------------------
module alu_arbiter
  import pipeline::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*3-1:0]    req_funct3,
  input  logic [N_REQ*7-1:0]    req_funct7,
  input  logic [N_REQ*XLEN-1:0] req_op1,
  input  logic [N_REQ*XLEN-1:0] req_op2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [XLEN-1:0]       rsp_result,
  output logic                  rsp_illegal
);
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_illegal_q, rsp_illegal_d;

  logic            can_accept;
  logic            found;
  logic            handshake;
  logic [ID_W-1:0] grant_id;
  logic [2:0]      sel_funct3;
  logic [6:0]      sel_funct7;
  logic [XLEN-1:0] sel_op1, sel_op2;
  logic [XLEN-1:0] alu_result;
  logic            alu_illegal;

  assign can_accept = !rsp_valid_q || rsp_ready;
  assign handshake  = found && can_accept;

  // Round-robin pick: first valid at or above rr_ptr, else wrap to the lowest valid.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i] && (i >= int'(rr_ptr_q))) begin
        found    = 1'b1;
        grant_id = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found    = 1'b1;
        grant_id = ID_W'(i);
      end
    end
  end

  // Route the winner's payload to the ALU and raise its ready when accepted.
  always_comb begin
    sel_funct3 = '0;
    sel_funct7 = '0;
    sel_op1    = '0;
    sel_op2    = '0;
    req_ready  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_funct3   = req_funct3[3*i +: 3];
        sel_funct7   = req_funct7[7*i +: 7];
        sel_op1      = req_op1[XLEN*i +: XLEN];
        sel_op2      = req_op2[XLEN*i +: XLEN];
        req_ready[i] = handshake;
      end
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .funct3  (sel_funct3),
    .funct7  (sel_funct7),
    .op1     (sel_op1),
    .op2     (sel_op2),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  // Buffer update: push overwrites (even while popping), pop-only clears valid.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_result_d  = rsp_result_q;
    rsp_illegal_d = rsp_illegal_q;
    if (handshake) begin
      rsp_valid_d   = 1'b1;
      rsp_id_d      = grant_id;
      rsp_result_d  = alu_result;
      rsp_illegal_d = alu_illegal;
      rr_ptr_d      = (grant_id == ID_W'(N_REQ-1)) ? '0 : (grant_id + ID_W'(1));
    end else if (rsp_ready) begin
      rsp_valid_d   = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_result_q  <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result_q  <= rsp_result_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_illegal = rsp_illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Self-checking bench for alu_arbiter (N_REQ=2, XLEN=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  import pipeline::*;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*3-1:0]  req_funct3 = '0;
  logic [N*7-1:0]  req_funct7 = '0;
  logic [N*32-1:0] req_op1 = '0;
  logic [N*32-1:0] req_op2 = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [0:0]      rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_illegal;

  int n_vec = 0;
  int n_err = 0;

  alu_arbiter #(.N_REQ(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_funct7  (req_funct7),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_illegal (rsp_illegal)
  );

  always #5 clk = ~clk;

  // Inputs are driven 1 time unit after the rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
    req_funct3[3*i +: 3]   = f3;
    req_funct7[7*i +: 7]   = f7;
    req_op1[32*i +: 32]    = a;
    req_op2[32*i +: 32]    = b;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Reference ALU straight from the RV integer op definitions.
  function automatic void ref_alu(input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ill);
    int sh;
    bit alt;
    sh  = int'(b % 32);
    alt = (f7 == 7'h20);
    ill = !((f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5)));
    r   = 32'd0;
    if (!ill) begin
      case (f3)
        3'd0: r = alt ? a - b : a + b;
        3'd1: r = a << sh;
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = alt ? 32'($signed(a) >>> sh) : a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
  endfunction

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_illegal, req_ready} !== 37'd0) begin
        n_err++;
        $display("FAIL reset_idle c%0d: got v=%b id=%0d res=%h ill=%b rdy=%b, want all zero",
                 c, rsp_valid, rsp_id, rsp_result, rsp_illegal, req_ready);
      end
      tick();
    end
  endtask

  task automatic test_single_op();
    do_reset();
    set_req(0, 3'd0, 7'h00, 32'd5, 32'd7);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL single_ready: got %b want 01", req_ready);
    end
    tick();
    req_valid = '0;
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_illegal} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin
      n_err++;
      $display("FAIL single_rsp: got v=%b id=%0d res=%h ill=%b, want v=1 id=0 res=0000000c ill=0",
               rsp_valid, rsp_id, rsp_result, rsp_illegal);
    end
    tick();
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pop: got v=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy [3] = '{2'b01, 2'b10, 2'b01};
    logic [31:0] exp_res [3] = '{32'hFFFFFFFE, 32'hF8000000, 32'hFFFFFFFE};
    do_reset();
    set_req(0, 3'd0, 7'h20, 32'd3, 32'd5);
    set_req(1, 3'd5, 7'h20, 32'h80000000, 32'd4);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (req_ready !== exp_rdy[k]) begin
        n_err++;
        $display("FAIL contention_ready%0d: got %b want %b", k, req_ready, exp_rdy[k]);
      end
      tick();
      if (k == 2) req_valid = '0;
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, exp_rdy[k][1], exp_res[k]}) begin
        n_err++;
        $display("FAIL contention_rsp%0d: got v=%b id=%0d res=%h, want v=1 id=%0d res=%h",
                 k, rsp_valid, rsp_id, rsp_result, exp_rdy[k][1], exp_res[k]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 3'd0, 7'h00, 32'd1, 32'd1);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    tick();
    set_req(1, 3'd4, 7'h00, 32'hF0, 32'hFF);
    req_valid = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_vec++;
      if (req_ready !== 2'b00) begin
        n_err++;
        $display("FAIL bp_ready c%0d: got %b want 00", c, req_ready);
      end
      tick();
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_illegal} !== {1'b1, 1'b0, 32'd2, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold c%0d: got v=%b id=%0d res=%h ill=%b, want v=1 id=0 res=00000002 ill=0",
                 c, rsp_valid, rsp_id, rsp_result, rsp_illegal);
      end
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 2'b10) begin
      n_err++;
      $display("FAIL bp_release_ready: got %b want 10", req_ready);
    end
    tick();
    req_valid = '0;
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'h0F}) begin
      n_err++;
      $display("FAIL bp_release_rsp: got v=%b id=%0d res=%h, want v=1 id=1 res=0000000f",
               rsp_valid, rsp_id, rsp_result);
    end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    set_req(0, 3'd0, 7'h00, 32'd9, 32'd9);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    tick();
    set_req(1, 3'd1, 7'h20, 32'hDEADBEEF, 32'd3);
    req_valid = 2'b10;
    #1;
    n_vec++;
    if (req_ready !== 2'b10) begin
      n_err++;
      $display("FAIL illegal_ready: got %b want 10", req_ready);
    end
    tick();
    req_valid = 2'b11;
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_illegal} !== {1'b1, 1'b1, 32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL illegal_rsp: got v=%b id=%0d res=%h ill=%b, want v=1 id=1 res=00000000 ill=1",
               rsp_valid, rsp_id, rsp_result, rsp_illegal);
    end
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL illegal_ptr_wrap: got ready %b want 01", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 3'd6, 7'h00, 32'h1234, 32'h8001);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    reset_n   = 1'b0;
    tick();
    reset_n = 1'b1;
    n_vec++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_illegal} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_mid_rsp: got v=%b id=%0d res=%h ill=%b, want all zero",
               rsp_valid, rsp_id, rsp_result, rsp_illegal);
    end
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL reset_mid_grant: got %b want 01", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int          m_ptr;
    bit          m_valid;
    int          m_id;
    logic [31:0] m_res;
    bit          m_ill;
    bit          found;
    int          win;
    logic [1:0]  exp_rdy;
    logic [31:0] r;
    bit          ill;
    int          sel;
    do_reset();
    m_ptr = 0; m_valid = 0; m_id = 0; m_res = '0; m_ill = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        sel = int'($urandom_range(0, 9));
        set_req(i, 3'($urandom_range(0, 7)),
                (sel < 5) ? 7'h00 : (sel < 8) ? 7'h20 : 7'($urandom),
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom),
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom));
      end
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      found = 0;
      win   = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req_valid[(m_ptr + k) % N]) begin
          found = 1;
          win   = (m_ptr + k) % N;
        end
      end
      exp_rdy = (found && (!m_valid || rsp_ready)) ? 2'(1 << win) : 2'b00;
      #1;
      n_vec++;
      if (req_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp_rdy);
      end
      tick();
      if (exp_rdy != 2'b00) begin
        ref_alu(req_funct3[3*win +: 3], req_funct7[7*win +: 7],
                req_op1[32*win +: 32], req_op2[32*win +: 32], r, ill);
        m_valid = 1;
        m_id    = win;
        m_res   = r;
        m_ill   = ill;
        m_ptr   = (win + 1) % N;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      n_vec++;
      if (rsp_valid !== m_valid ||
          (m_valid && (rsp_id !== 1'(m_id) || rsp_result !== m_res || rsp_illegal !== m_ill))) begin
        n_err++;
        $display("FAIL rand_rsp c%0d: got v=%b id=%0d res=%h ill=%b, want v=%b id=%0d res=%h ill=%b",
                 c, rsp_valid, rsp_id, rsp_result, rsp_illegal, m_valid, m_id, m_res, m_ill);
      end
    end
    req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
